ctrl_cmd_reg: RTL and testbench
===============================

CTRL_CMD_REG -- requirements
Module: ctrl_cmd_reg

Interface
REQ-001 Parameter DW, default 8: CPU data width and width of ctrl_o/cmd_o; minimum 4.
REQ-002 Parameter CTRL_RST, default {DW{1'b0}}: reset value of the CTRL register.
REQ-003 Parameter TO_CYC, default 16: maximum REQ-state cycles before timeout; range 1..255.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 cpuaddr_i  in  2  register select: 0 CTRL, 1 CMD, 2 STAT, 3 IEN.
REQ-007 cpuren_i  in  1  read enable.
REQ-008 cpuwen_i  in  1  write enable.
REQ-009 cpudi_i  in  DW  write data from the CPU.
REQ-010 cpudo_o  out  DW  read data to the CPU.
REQ-011 ctrl_o  out  DW  static control word to the IP.
REQ-012 cmd_o  out  DW  command word to the IP; valid while req_o=1.
REQ-013 req_o  out  1  command request to the IP (4-phase handshake).
REQ-014 ack_i  in  1  command acknowledge from the IP; synchronous to clk.
REQ-015 irq_o  out  1  interrupt, level, registered.

Function
REQ-016 Write to CTRL: ctrl_o <= cpudi_i at the sampling edge; ctrl_o is fed directly from the register.
REQ-017 Write to IEN: ien[2:0] <= cpudi_i[2:0]; the upper bits are ignored.
REQ-018 STAT word: bit0 busy, bit1 done, bit2 timeout, bit3 overrun, bits DW-1:4 = 0.
REQ-019 busy = (state != IDLE), combinational from the state register.
REQ-020 STAT bits 1..3 are sticky; a write to STAT clears each bit where cpudi_i is 1 (W1C); bit0 is read-only.
REQ-021 Set and W1C on the same bit in the same cycle: set wins.
REQ-022 Read: cpudo_o = cpuren_i ? selected register : 0, combinational, same cycle; CMD reads back the latched cmd word.
REQ-023 Reads have no side effects.
REQ-024 FSM states: IDLE, REQ, REL.
REQ-025 IDLE + CMD write: cmd_o <= cpudi_i, go to REQ; req_o is high from the next cycle (1-cycle latency).
REQ-026 REQ: req_o=1 and cmd_o is held stable; ack_i=1 goes to REL and sets done.
REQ-027 REQ timeout: if ack_i has not been sampled high after TO_CYC REQ cycles, go to IDLE, req_o=0, set timeout.
REQ-028 ack_i sampled high on the final timeout cycle: ack wins (REL, done set, timeout not set).
REQ-029 REL: req_o=0; ack_i=0 returns to IDLE; REL has no timeout.
REQ-030 A late ack_i arriving in IDLE is ignored.
REQ-031 CMD write while busy: the command is dropped, cmd_o is unchanged, and overrun is set.
REQ-032 Timeout counter: 8-bit, cleared on entry to REQ, increments each REQ cycle, saturating.
REQ-033 irq_o <= |(STAT[3:1] & ien[2:0]), registered (1-cycle lag after a flag changes).
REQ-034 cpuwen_i and cpuren_i may be high in the same cycle; the read returns the pre-write value.

Reset
REQ-035 rst_n=0 forces, asynchronously: state IDLE, req_o=0, cmd_o=0, ctrl_o=CTRL_RST, ien=0, STAT flags=0, irq_o=0, counter=0.
REQ-036 Reset asserted mid-handshake aborts the handshake immediately and drops req_o; no done or timeout flag is recorded.
REQ-037 cpudo_o stays combinational and is 0 whenever cpuren_i=0, including during reset.

Verification
REQ-038 Write CTRL=0xA5, then read addr 0 -> cpudo_o=0xA5, ctrl_o=0xA5; with cpuren_i=0 -> cpudo_o=0x00.
REQ-039 Write CMD=0x3C; ack_i rises 3 cycles after req_o and falls 2 cycles after req_o drops -> req_o high one cycle after the write, cmd_o=0x3C throughout, STAT=0x02 after return to IDLE, busy=1 during the handshake.
REQ-040 TO_CYC=16, ack_i held low -> req_o drops after 16 REQ cycles, STAT=0x04; irq_o=1 one cycle later when ien=0x2; W1C 0x04 -> STAT=0x00 and irq_o=0 one cycle later.
REQ-041 Write CMD=0x11 then CMD=0x22 while busy -> cmd_o stays 0x11, STAT bit3=1; ack_i rising on the timeout cycle -> done=1, timeout=0.
REQ-042 Assert rst_n=0 while in REQ -> req_o=0 immediately; after release, STAT=0x00, ctrl_o=CTRL_RST, cmd_o=0x00.

Source files
------------

// File: rtl/ctrl_cmd_reg.sv
// CPU-visible control/command register block: static CTRL word, CMD word with a
// 4-phase req/ack handshake to the IP, sticky status flags and a level interrupt.
module ctrl_cmd_reg #(
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   CTRL_RST = '0,
    parameter int              TO_CYC   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    cpuaddr_i,
    input  logic          cpuren_i,
    input  logic          cpuwen_i,
    input  logic [DW-1:0] cpudi_i,
    output logic [DW-1:0] cpudo_o,
    output logic [DW-1:0] ctrl_o,
    output logic [DW-1:0] cmd_o,
    output logic          req_o,
    input  logic          ack_i,
    output logic          irq_o
);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] ctrl_q, cmd_q;
    logic [2:0]    ien_q;
    logic [2:0]    flags_q, flags_d;   // {overrun, timeout, done}
    logic          irq_q;

    logic          ctrl_wr, cmd_wr, stat_wr, ien_wr;
    logic          cmd_ld, set_done, set_to, set_ovr;
    logic          busy;
    logic [2:0]    clr;

    assign ctrl_wr = cpuwen_i && (cpuaddr_i == 2'd0);
    assign cmd_wr  = cpuwen_i && (cpuaddr_i == 2'd1);
    assign stat_wr = cpuwen_i && (cpuaddr_i == 2'd2);
    assign ien_wr  = cpuwen_i && (cpuaddr_i == 2'd3);

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_ld   = 1'b0;
        set_done = 1'b0;
        set_to   = 1'b0;
        set_ovr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_wr) begin
                    cmd_ld  = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                set_ovr = cmd_wr;
                cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                // ack is checked first so it wins on the final timeout cycle
                if (ack_i) begin
                    set_done = 1'b1;
                    state_d  = REL;
                end else if (cnt_q == TO_LAST) begin
                    set_to  = 1'b1;
                    state_d = IDLE;
                end
            end
            REL: begin
                set_ovr = cmd_wr;
                if (!ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr     = stat_wr ? cpudi_i[3:1] : '0;
    assign flags_d = (flags_q & ~clr) | {set_ovr, set_to, set_done};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_RST;
            cmd_q   <= '0;
            ien_q   <= '0;
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            irq_q   <= |(flags_q & ien_q);
            if (ctrl_wr) ctrl_q <= cpudi_i;
            if (cmd_ld)  cmd_q  <= cpudi_i;
            if (ien_wr)  ien_q  <= cpudi_i[2:0];
        end
    end

    always_comb begin
        cpudo_o = '0;
        if (cpuren_i) begin
            case (cpuaddr_i)
                2'd0: cpudo_o = ctrl_q;
                2'd1: cpudo_o = cmd_q;
                2'd2: cpudo_o = {{(DW-4){1'b0}}, flags_q, busy};
                2'd3: cpudo_o = {{(DW-3){1'b0}}, ien_q};
                default: cpudo_o = '0;
            endcase
        end
    end

    assign ctrl_o = ctrl_q;
    assign cmd_o  = cmd_q;
    assign req_o  = (state_q == REQ);
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_ctrl_cmd_reg.sv
// Directed bench for ctrl_cmd_reg: register access table plus handshake,
// timeout, overrun and mid-handshake reset sequences.
module tb_ctrl_cmd_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cpuaddr_i = '0;
    logic       cpuren_i = 1'b0;
    logic       cpuwen_i = 1'b0;
    logic [7:0] cpudi_i = '0;
    logic [7:0] cpudo_o, ctrl_o, cmd_o;
    logic       req_o, irq_o;
    logic       ack_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_cmd_reg #(.DW(8), .CTRL_RST(8'h5A), .TO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpuaddr_i(cpuaddr_i), .cpuren_i(cpuren_i),
        .cpuwen_i(cpuwen_i), .cpudi_i(cpudi_i), .cpudo_o(cpudo_o), .ctrl_o(ctrl_o),
        .cmd_o(cmd_o), .req_o(req_o), .ack_i(ack_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        logic       ren;
        logic [1:0] addr;
        logic [7:0] di;
        logic [7:0] exp_do;
        logic [7:0] exp_ctrl;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stat_chk(input string name, input logic [7:0] exp);
        cpuaddr_i = 2'd2;
        cpuren_i  = 1'b1;
        #1;
        chk(name, cpudo_o, exp);
        cpuren_i  = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpuaddr_i = addr;
        cpudi_i   = data;
        cpuwen_i  = 1'b1;
        @(posedge clk);
        #1 cpuwen_i = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{0, 1, 2'd0, 8'h00, 8'h5A, 8'h5A};
        vecs[1]  = '{1, 0, 2'd0, 8'hA5, 8'h00, 8'hA5};
        vecs[2]  = '{0, 1, 2'd0, 8'h00, 8'hA5, 8'hA5};
        vecs[3]  = '{0, 0, 2'd0, 8'h00, 8'h00, 8'hA5};
        vecs[4]  = '{1, 1, 2'd0, 8'h33, 8'hA5, 8'h33};
        vecs[5]  = '{0, 1, 2'd0, 8'h00, 8'h33, 8'h33};
        vecs[6]  = '{1, 0, 2'd0, 8'hA5, 8'h00, 8'hA5};
        vecs[7]  = '{1, 0, 2'd3, 8'hFA, 8'h00, 8'hA5};
        vecs[8]  = '{0, 1, 2'd3, 8'h00, 8'h02, 8'hA5};
        vecs[9]  = '{0, 1, 2'd2, 8'h00, 8'h00, 8'hA5};
        vecs[10] = '{0, 1, 2'd1, 8'h00, 8'h00, 8'hA5};
        vecs[11] = '{1, 1, 2'd2, 8'hFF, 8'h00, 8'hA5};
        vecs[12] = '{0, 1, 2'd2, 8'h00, 8'h00, 8'hA5};

        repeat (3) @(negedge clk);
        chk("rst_req", req_o, 1'b0);
        chk("rst_cmd", cmd_o, 8'h00);
        chk("rst_ctrl", ctrl_o, 8'h5A);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_do_ren0", cpudo_o, 8'h00);
        rst_n = 1'b1;

        // Register access table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            cpuwen_i  = vecs[i].wen;
            cpuren_i  = vecs[i].ren;
            cpuaddr_i = vecs[i].addr;
            cpudi_i   = vecs[i].di;
            #1 chk($sformatf("vec%0d_do", i), cpudo_o, vecs[i].exp_do);
            @(posedge clk);
            #1;
            cpuwen_i = 1'b0;
            cpuren_i = 1'b0;
            chk($sformatf("vec%0d_ctrl", i), ctrl_o, vecs[i].exp_ctrl);
        end

        // Normal handshake: ack rises 3 cycles after req_o, falls 2 after it drops
        @(negedge clk);
        cpuaddr_i = 2'd1; cpudi_i = 8'h3C; cpuwen_i = 1'b1;
        #1 chk("hs_req_before_edge", req_o, 1'b0);
        @(posedge clk);
        #1 cpuwen_i = 1'b0;
        @(negedge clk);
        chk("hs_req_n1", req_o, 1'b1);
        chk("hs_cmd_n1", cmd_o, 8'h3C);
        stat_chk("hs_busy_n1", 8'h01);
        @(negedge clk);
        chk("hs_req_n2", req_o, 1'b1);
        chk("hs_cmd_n2", cmd_o, 8'h3C);
        @(negedge clk);
        chk("hs_req_n3", req_o, 1'b1);
        ack_i = 1'b1;
        @(negedge clk);
        chk("hs_req_rel", req_o, 1'b0);
        chk("hs_cmd_rel", cmd_o, 8'h3C);
        stat_chk("hs_stat_rel", 8'h03);
        @(negedge clk);
        ack_i = 1'b0;
        stat_chk("hs_stat_rel2", 8'h03);
        @(negedge clk);
        stat_chk("hs_stat_idle", 8'h02);
        chk("hs_req_idle", req_o, 1'b0);
        @(negedge clk);
        chk("hs_irq_masked", irq_o, 1'b0);
        cpu_write(2'd2, 8'h02);
        @(negedge clk);
        stat_chk("hs_w1c_done", 8'h00);

        // Timeout with ack held low, ien=0x2 enables timeout interrupt
        cpu_write(2'd1, 8'h55);
        n = 0;
        @(negedge clk);
        while (req_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 16);
        stat_chk("to_stat", 8'h04);
        chk("to_irq_lag", irq_o, 1'b0);
        @(negedge clk);
        chk("to_irq", irq_o, 1'b1);
        cpu_write(2'd2, 8'h04);
        @(negedge clk);
        stat_chk("to_w1c", 8'h00);
        chk("to_irq_w1c_lag", irq_o, 1'b1);
        @(negedge clk);
        chk("to_irq_clr", irq_o, 1'b0);

        // Overrun while busy, then ack on the final timeout cycle
        cpu_write(2'd1, 8'h11);
        cpu_write(2'd1, 8'h22);
        @(negedge clk);
        chk("ovr_cmd", cmd_o, 8'h11);
        stat_chk("ovr_stat", 8'h09);
        repeat (14) @(negedge clk);
        chk("ovr_req_last", req_o, 1'b1);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        chk("lastack_req", req_o, 1'b0);
        stat_chk("lastack_stat_rel", 8'h0B);
        @(negedge clk);
        stat_chk("lastack_stat_idle", 8'h0A);
        chk("lastack_irq", irq_o, 1'b0);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        stat_chk("late_ack_stat", 8'h0A);
        chk("late_ack_req", req_o, 1'b0);
        cpu_write(2'd2, 8'h0E);
        @(negedge clk);
        stat_chk("w1c_all", 8'h00);

        // Reset asserted while in REQ
        cpu_write(2'd1, 8'h77);
        @(negedge clk);
        chk("rst_hs_req", req_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hs_req_drop", req_o, 1'b0);
        chk("rst_hs_cmd", cmd_o, 8'h00);
        chk("rst_hs_ctrl", ctrl_o, 8'h5A);
        chk("rst_hs_do_ren0", cpudo_o, 8'h00);
        cpuaddr_i = 2'd0; cpuren_i = 1'b1;
        #1 chk("rst_hs_do_ctrl", cpudo_o, 8'h5A);
        cpuren_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stat_chk("rst_rel_stat", 8'h00);
        chk("rst_rel_ctrl", ctrl_o, 8'h5A);
        chk("rst_rel_cmd", cmd_o, 8'h00);
        chk("rst_rel_irq", irq_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
